dmem_host_port: RTL and testbench

Host-side master for the data memory's debug port B: it sequences single and burst word transfers between a host register interface and the `dmem_prog_*` BRAM port. The block sits between the host register block and the data-memory stage. It is used to preload data memory before a run and to read results back afterward. It hides the one-cycle synchronous read latency of the BRAM behind a valid/ready read stream.

---
 rtl/dmem_host_pkg.sv | 17 +
 rtl/dmem_host_port.sv | 102 ++++++++++
 tb/tb_dmem_host_port.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_host_pkg.sv
// Shared types for the data-memory host port.
// Holds the FSM state encoding and default BRAM word geometry.
package dmem_host_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/dmem_host_port.sv
// Host-side master for data-memory port B: single/burst word transfers.
// Ports: cmd_* (burst request), wr_* (write stream in), rd_* (read stream
// out), busy/done status, dmem_prog_* (BRAM port B, 1-cycle read latency).
module dmem_host_port
    import dmem_host_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_W,
    parameter int DATA_WIDTH = DMEM_DATA_W,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  dmem_prog_en,
    output logic                  dmem_prog_we,
    output logic [ADDR_WIDTH-1:0] dmem_prog_addr,
    output logic [DATA_WIDTH-1:0] dmem_prog_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_prog_rdata
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remain;
    logic                  last;

    assign last = (remain == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            remain   <= '0;
            rd_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr <= cmd_addr;
                        remain   <= cmd_len;
                        state    <= cmd_write ? WR : RD_ISSUE;
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        if (last) begin
                            state <= DONE;
                        end else begin
                            cur_addr <= cur_addr + ADDR_WIDTH'(1);
                            remain   <= remain - LEN_WIDTH'(1);
                        end
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                // BRAM output is valid this cycle; register it so the
                // host sees a stable word however long it stalls.
                RD_WAIT: begin
                    rd_data <= dmem_prog_rdata;
                    state   <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        if (last) begin
                            state <= DONE;
                        end else begin
                            cur_addr <= cur_addr + ADDR_WIDTH'(1);
                            remain   <= remain - LEN_WIDTH'(1);
                            state    <= RD_ISSUE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == WR);
    assign rd_valid  = (state == RD_HOLD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Writes go straight through from the stream, so a stalled
    // write stream leaves the port idle.
    assign dmem_prog_we    = (state == WR) && wr_valid;
    assign dmem_prog_en    = dmem_prog_we || (state == RD_ISSUE);
    assign dmem_prog_addr  = cur_addr;
    assign dmem_prog_wdata = wr_data;

endmodule

// File: tb/tb_dmem_host_port.sv
// Testbench for dmem_host_port with a 1-cycle-latency BRAM model.
// Table-driven bursts plus hand sequences for reset and busy behaviour.
module tb_dmem_host_port;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic        busy;
    logic        done;
    logic        dmem_prog_en;
    logic        dmem_prog_we;
    logic [7:0]  dmem_prog_addr;
    logic [63:0] dmem_prog_wdata;
    logic [63:0] dmem_prog_rdata;

    dmem_host_port dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .dmem_prog_en   (dmem_prog_en),
        .dmem_prog_we   (dmem_prog_we),
        .dmem_prog_addr (dmem_prog_addr),
        .dmem_prog_wdata(dmem_prog_wdata),
        .dmem_prog_rdata(dmem_prog_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [256];
    always @(posedge clk) begin
        if (dmem_prog_en) begin
            if (dmem_prog_we) mem[dmem_prog_addr] <= dmem_prog_wdata;
            else              dmem_prog_rdata <= mem[dmem_prog_addr];
        end
    end

    int dcnt = 0;
    int wcnt = 0;
    always @(posedge clk) begin
        if (done)         dcnt <= dcnt + 1;
        if (dmem_prog_we) wcnt <= wcnt + 1;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic            wr;
        logic [7:0]      addr;
        logic [7:0]      len;
        logic [3:0][63:0] d;
        logic [7:0]      stall_at;
        logic [7:0]      stall_n;
        logic [7:0]      done_cyc;
    } vec_t;

    vec_t vt [8];

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int d0;
        int w0;
        int k;
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        #1;
        chk({p, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        d0 = dcnt;
        w0 = wcnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        for (int i = 0; i <= int'(v.len); i++) begin
            if (v.wr) begin
                if (i == int'(v.stall_at)) begin
                    for (int s = 0; s < int'(v.stall_n); s++) begin
                        wr_valid = 1'b0;
                        #1;
                        chk({p, "_gap_en"}, 64'(dmem_prog_en), 64'd0);
                        @(negedge clk);
                        cyc++;
                    end
                end
                wr_valid = 1'b1;
                wr_data  = v.d[i];
                #1;
                chk({p, "_we"}, 64'(dmem_prog_en & dmem_prog_we), 64'd1);
                chk({p, "_waddr"}, 64'(dmem_prog_addr),
                    64'(8'(v.addr + 8'(i))));
                @(negedge clk);
                cyc++;
                wr_valid = 1'b0;
            end else begin
                k = 0;
                while (!rd_valid && k < 20) begin
                    @(negedge clk);
                    cyc++;
                    k++;
                end
                chk({p, "_rd_valid"}, 64'(rd_valid), 64'd1);
                if (i == 0) chk({p, "_first_cyc"}, 64'(cyc), 64'd3);
                if (i == int'(v.stall_at)) begin
                    for (int s = 0; s < int'(v.stall_n); s++) begin
                        chk({p, "_stall_data"}, rd_data, v.d[i]);
                        @(negedge clk);
                        cyc++;
                    end
                end
                chk({p, "_rd_data"}, rd_data, v.d[i]);
                rd_ready = 1'b1;
                @(negedge clk);
                cyc++;
                rd_ready = 1'b0;
            end
        end
        #1;
        chk({p, "_done"}, 64'(done), 64'd1);
        chk({p, "_done_cyc"}, 64'(cyc), 64'(v.done_cyc));
        @(negedge clk);
        chk({p, "_idle"}, 64'({done, cmd_ready, busy}), 64'b010);
        chk({p, "_ndone"}, 64'(dcnt - d0), 64'd1);
        if (v.wr) chk({p, "_nwr"}, 64'(wcnt - w0), 64'(int'(v.len) + 1));
        else      chk({p, "_rd_nowe"}, 64'(wcnt - w0), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        vt[0] = '{1'b1, 8'h10, 8'd0,
                  {64'd0, 64'd0, 64'd0, 64'hDEADBEEF_00000001},
                  8'hFF, 8'd0, 8'd2};
        vt[1] = '{1'b0, 8'h10, 8'd0,
                  {64'd0, 64'd0, 64'd0, 64'hDEADBEEF_00000001},
                  8'hFF, 8'd0, 8'd4};
        vt[2] = '{1'b1, 8'hFE, 8'd3,
                  {64'd4, 64'd3, 64'd2, 64'd1},
                  8'hFF, 8'd0, 8'd5};
        vt[3] = '{1'b0, 8'hFE, 8'd3,
                  {64'd4, 64'd3, 64'd2, 64'd1},
                  8'hFF, 8'd0, 8'd13};
        vt[4] = '{1'b0, 8'hFE, 8'd3,
                  {64'd4, 64'd3, 64'd2, 64'd1},
                  8'd1, 8'd5, 8'd18};
        vt[5] = '{1'b1, 8'h20, 8'd3,
                  {64'hD, 64'hC, 64'hB, 64'hA},
                  8'd2, 8'd3, 8'd8};
        vt[6] = '{1'b0, 8'h20, 8'd3,
                  {64'hD, 64'hC, 64'hB, 64'hA},
                  8'hFF, 8'd0, 8'd13};
        vt[7] = '{1'b0, 8'h00, 8'd0,
                  {64'd0, 64'd0, 64'd0, 64'd3},
                  8'hFF, 8'd0, 8'd4};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_outs",
            64'({cmd_ready, wr_ready, rd_valid, busy, done,
                 dmem_prog_en, dmem_prog_we}), 64'b1000000);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_addr", 64'(dmem_prog_addr), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        chk("mem_fe", mem[8'hFE], 64'd1);
        chk("mem_ff", mem[8'hFF], 64'd2);
        chk("mem_00", mem[8'h00], 64'd3);
        chk("mem_01", mem[8'h01], 64'd4);
        chk("mem_22", mem[8'h22], 64'hC);

        // reset while a read word is held
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        cmd_len   = 8'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_hold", 64'(rd_valid), 64'd1);
        k = dcnt;
        rst_n = 1'b0;
        #1;
        chk("abort_outs",
            64'({cmd_ready, wr_ready, rd_valid, busy, done,
                 dmem_prog_en, dmem_prog_we}), 64'b1000000);
        chk("abort_rd_data", rd_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 64'({cmd_ready, busy}), 64'b10);
        chk("abort_ndone", 64'(dcnt - k), 64'd0);

        // command held while a 2-word write is in flight
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h30;
        cmd_len   = 8'd1;
        @(negedge clk);
        cmd_write = 1'b0;
        cmd_len   = 8'd0;
        wr_valid  = 1'b1;
        wr_data   = 64'h55;
        #1;
        chk("busy_c1", 64'({cmd_ready, busy}), 64'b01);
        @(negedge clk);
        wr_data = 64'h66;
        #1;
        chk("busy_c2", 64'({cmd_ready, busy}), 64'b01);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        chk("busy_c3_done", 64'({cmd_ready, done}), 64'b01);
        @(negedge clk);
        chk("busy_c4_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("busy_issue",
            64'({dmem_prog_en, dmem_prog_we, dmem_prog_addr}),
            64'({1'b1, 1'b0, 8'h30}));
        k = 0;
        while (!rd_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("busy_rd", rd_data, 64'h55);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        #1;
        chk("busy_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("busy_idle", 64'({cmd_ready, busy}), 64'b10);
        chk("mem_31", mem[8'h31], 64'h66);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
